// File: rtl/router_sched_pkg.sv
// Shared types and width helpers for the mesh router output scheduler.
package router_sched_pkg;

  localparam int unsigned StatWidth = 32;

  // Field order puts idle in the MSBs of the packed statistics word.
  typedef struct packed {
    logic [StatWidth-1:0] idle;
    logic [StatWidth-1:0] utilized;
    logic [StatWidth-1:0] stalled;
    logic [StatWidth-1:0] arbitrated;
  } router_sched_stat_s;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/router_sched_rr_pick.sv
// One-hot picker: first set request found scanning upward from start_i, modulo n_p.
module router_sched_rr_pick #(
  parameter int unsigned n_p     = 5,
  parameter int unsigned ptr_w_p = 3
) (
  input  logic [n_p-1:0]     req_i,
  input  logic [ptr_w_p-1:0] start_i,
  output logic [n_p-1:0]     grant_o,
  output logic [ptr_w_p-1:0] idx_o
);

  int unsigned        w_j;
  logic [ptr_w_p-1:0] w_j_idx;
  logic               w_found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_j     = 0;
    w_j_idx = '0;
    for (int unsigned k = 0; k < n_p; k++) begin
      w_j     = (32'(start_i) + k) % n_p;
      w_j_idx = ptr_w_p'(w_j);
      if (!w_found && req_i[w_j_idx]) begin
        grant_o[w_j_idx] = 1'b1;
        idx_o            = w_j_idx;
        w_found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_router_output_scheduler.sv
// Per-output round-robin scheduler with yumi handshake and profiling counters.
// Define ROUTER_SCHED_STARVE_GUARD_EN to add per-input starvation override.
module mesh_router_output_scheduler
  import router_sched_pkg::*;
#(
  parameter int unsigned dirs_p         = 5,
  parameter int unsigned starve_limit_p = 16,
  parameter int unsigned stat_width_p   = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [dirs_p-1:0]         req_i,
  input  logic                      ready_i,
  output logic                      v_o,
  output logic [dirs_p-1:0]         grant_o,
  output logic [dirs_p-1:0]         yumi_o,
  input  logic                      clear_stat_i,
  output logic [4*stat_width_p-1:0] stat_o
);

  localparam int unsigned     PtrW    = ptr_width(dirs_p);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(dirs_p - 1);

  logic [PtrW-1:0]   r_last;
  logic [PtrW-1:0]   w_start;
  logic [PtrW-1:0]   w_rr_idx;
  logic [PtrW-1:0]   w_sel_idx;
  logic [dirs_p-1:0] w_rr_grant;
  logic [dirs_p-1:0] w_sel_grant;
  logic              w_fire;

  assign w_start = (r_last == LastIdx) ? '0 : r_last + 1'b1;

  router_sched_rr_pick #(
    .n_p     (dirs_p),
    .ptr_w_p (PtrW)
  ) u_rr_pick (
    .req_i   (req_i),
    .start_i (w_start),
    .grant_o (w_rr_grant),
    .idx_o   (w_rr_idx)
  );

`ifdef ROUTER_SCHED_STARVE_GUARD_EN
  localparam int unsigned      WaitW   = cnt_width(starve_limit_p);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(starve_limit_p);

  logic [WaitW-1:0]  r_wait [dirs_p];
  logic [dirs_p-1:0] w_starving;
  logic [dirs_p-1:0] w_starve_grant;
  logic [PtrW-1:0]   w_starve_idx;

  always_comb begin
    w_starving = '0;
    for (int unsigned i = 0; i < dirs_p; i++) begin
      w_starving[i] = req_i[i] & (r_wait[i] == WaitMax);
    end
  end

  // Fixed priority from index 0 among starving inputs.
  router_sched_rr_pick #(
    .n_p     (dirs_p),
    .ptr_w_p (PtrW)
  ) u_starve_pick (
    .req_i   (w_starving),
    .start_i ('0),
    .grant_o (w_starve_grant),
    .idx_o   (w_starve_idx)
  );

  assign w_sel_grant = (|w_starving) ? w_starve_grant : w_rr_grant;
  assign w_sel_idx   = (|w_starving) ? w_starve_idx   : w_rr_idx;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < dirs_p; i++) r_wait[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < dirs_p; i++) begin
        if (!req_i[i] || yumi_o[i]) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != WaitMax) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_sel_grant = w_rr_grant;
  assign w_sel_idx   = w_rr_idx;
`endif

  assign v_o     = (|req_i) & ~reset_i;
  assign grant_o = w_sel_grant & {dirs_p{~reset_i}};
  assign yumi_o  = grant_o & {dirs_p{ready_i}};
  assign w_fire  = v_o & ready_i;

  // Pointer only advances on a completed handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_last <= LastIdx;
    end else if (w_fire) begin
      r_last <= w_sel_idx;
    end
  end

  logic [stat_width_p-1:0] r_idle;
  logic [stat_width_p-1:0] r_util;
  logic [stat_width_p-1:0] r_stall;
  logic [stat_width_p-1:0] r_arb;
  logic                    w_idle;
  logic                    w_stall;
  logic                    w_arb;

  assign w_idle  = ~|req_i;
  assign w_stall = v_o & ~ready_i;
  assign w_arb   = ($countones(req_i) > 1) && ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_idle  <= '0;
      r_util  <= '0;
      r_stall <= '0;
      r_arb   <= '0;
    end else if (clear_stat_i) begin
      r_idle  <= '0;
      r_util  <= '0;
      r_stall <= '0;
      r_arb   <= '0;
    end else begin
      if (w_idle)  r_idle  <= r_idle + 1'b1;
      if (w_fire)  r_util  <= r_util + 1'b1;
      if (w_stall) r_stall <= r_stall + 1'b1;
      if (w_arb)   r_arb   <= r_arb + 1'b1;
    end
  end

  assign stat_o = {r_idle, r_util, r_stall, r_arb};

`ifndef SYNTHESIS
  logic [dirs_p-1:0] r_req_prev;
  logic [dirs_p-1:0] r_yumi_prev;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_req_prev  <= '0;
      r_yumi_prev <= '0;
    end else begin
      r_req_prev  <= req_i;
      r_yumi_prev <= yumi_o;
    end
  end

  // A request may only be withdrawn in the cycle after it was dequeued.
  a_req_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    ((r_req_prev & ~req_i & ~r_yumi_prev) == '0))
    else $error("req_i dropped without yumi_o");
`endif

endmodule

// File: tb/tb_mesh_router_output_scheduler.sv
// Self-checking bench for mesh_router_output_scheduler with a behavioural scheduler model.
module tb_mesh_router_output_scheduler;
  import router_sched_pkg::*;

  localparam int N     = 5;
  localparam int LIMIT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   req;
  logic         ready;
  logic         clear;
  logic         v;
  logic [4:0]   grant;
  logic [4:0]   yumi;
  logic [127:0] stat;
  router_sched_stat_s st;

  assign st = stat;

  always #5 clk = ~clk;

  mesh_router_output_scheduler #(
    .dirs_p         (N),
    .starve_limit_p (LIMIT),
    .stat_width_p   (32)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .req_i        (req),
    .ready_i      (ready),
    .v_o          (v),
    .grant_o      (grant),
    .yumi_o       (yumi),
    .clear_stat_i (clear),
    .stat_o       (stat)
  );

  int tests = 0;
  int fails = 0;

  // Model state: last served index, per-input waiting time, four counters.
  int          m_last;
  int          m_wait [N];
  logic [31:0] m_idle, m_util, m_stall, m_arb;

  function automatic logic [4:0] model_pick(input logic [4:0] r);
`ifdef ROUTER_SCHED_STARVE_GUARD_EN
    for (int i = 0; i < N; i++) if (r[i] && m_wait[i] == LIMIT) return 5'(1 << i);
`endif
    for (int k = 1; k <= N; k++) begin
      int idx = (m_last + k) % N;
      if (r[idx]) return 5'(1 << idx);
    end
    return 5'b0;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_idle = 0; m_util = 0; m_stall = 0; m_arb = 0;
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    logic [4:0] g, y;
    g = model_pick(req);
    y = ready ? g : 5'b0;
    @(posedge clk);
    if (clear) begin
      m_idle = 0; m_util = 0; m_stall = 0; m_arb = 0;
    end else begin
      if (req == 0) m_idle++;
      if (req != 0 && ready) m_util++;
      if (req != 0 && !ready) m_stall++;
      if ($countones(req) > 1 && ready) m_arb++;
    end
    if (req != 0 && ready) for (int i = 0; i < N; i++) if (g[i]) m_last = i;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || y[i]) m_wait[i] = 0;
      else if (m_wait[i] < LIMIT) m_wait[i]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ready = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; ready = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    if ({v, grant, yumi} !== 11'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b g=%b y=%b want all 0", v, grant, yumi);
    end
    tests++;
    if (stat !== 128'b0) begin
      fails++;
      $display("FAIL reset_stats: got %h want 0", stat);
    end
    tests++;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    #4;
    if (grant !== 5'b00001 || yumi !== 5'b00001 || v !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: got g=%b y=%b want 00001", grant, yumi);
    end
    tests++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g [4] = '{5'b00010, 5'b00100, 5'b00010, 5'b00100};
    do_reset();
    req = 5'b00110; ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      if (v !== 1'b1 || grant !== exp_g[c] || yumi !== exp_g[c]) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got v=%b g=%b y=%b want g=y=%b", c, v, grant, yumi, exp_g[c]);
      end
      tests++;
      tick();
    end
    #4;
    if ({st.idle, st.utilized, st.stalled, st.arbitrated} !== {32'd0, 32'd4, 32'd0, 32'd4}) begin
      fails++;
      $display("FAIL rr_stats: got %0d/%0d/%0d/%0d want 0/4/0/4",
               st.idle, st.utilized, st.stalled, st.arbitrated);
    end
    tests++;
  endtask

  task automatic test_stall();
    do_reset();
    req = 5'b11111; ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic [4:0] eg;
      if (c == 3) ready = 1'b1;
      eg = (c < 3) ? 5'b00001 : 5'(1 << (c - 3));
      #4;
      if (grant !== eg || yumi !== (ready ? eg : 5'b0) || v !== 1'b1) begin
        fails++;
        $display("FAIL stall_grant[%0d]: got g=%b y=%b want g=%b", c, grant, yumi, eg);
      end
      tests++;
      tick();
    end
    #4;
    if (st.stalled !== 32'd3 || st.utilized !== 32'd5 || st.idle !== 32'd0) begin
      fails++;
      $display("FAIL stall_stats: got stalled=%0d util=%0d idle=%0d want 3/5/0",
               st.stalled, st.utilized, st.idle);
    end
    tests++;
  endtask

  task automatic test_wrap();
    logic [4:0] rq  [3] = '{5'b10000, 5'b10001, 5'b10000};
    logic [4:0] exp [3] = '{5'b10000, 5'b00001, 5'b10000};
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req = rq[c];
      #4;
      if (grant !== exp[c] || yumi !== exp[c]) begin
        fails++;
        $display("FAIL wrap_grant[%0d]: got g=%b y=%b want %b", c, grant, yumi, exp[c]);
      end
      tests++;
      tick();
    end
  endtask

  task automatic test_starve();
    logic [4:0] rq  [4] = '{5'b01000, 5'b01011, 5'b01011, 5'b01011};
    logic       rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ROUTER_SCHED_STARVE_GUARD_EN
    logic [4:0] exp [4] = '{5'b01000, 5'b00001, 5'b01000, 5'b00001};
`else
    logic [4:0] exp [4] = '{5'b01000, 5'b00001, 5'b00001, 5'b00010};
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req = rq[c]; ready = rdy[c];
      #4;
      if (grant !== exp[c] || yumi !== (ready ? exp[c] : 5'b0)) begin
        fails++;
        $display("FAIL starve_grant[%0d]: got g=%b y=%b want g=%b", c, grant, yumi, exp[c]);
      end
      tests++;
      tick();
    end
  endtask

  task automatic test_clear();
    logic [4:0] rq  [5] = '{5'b00011, 5'b00011, 5'b00011, 5'b00010, 5'b00100};
    logic       rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    repeat (7) tick();
    for (int c = 0; c < 5; c++) begin
      req = rq[c]; ready = rdy[c];
      tick();
    end
    req = 5'b01000; ready = 1'b1; clear = 1'b1;
    #4;
    if ({st.idle, st.utilized, st.stalled, st.arbitrated} !== {32'd7, 32'd3, 32'd2, 32'd1}) begin
      fails++;
      $display("FAIL clear_pre: got %0d/%0d/%0d/%0d want 7/3/2/1",
               st.idle, st.utilized, st.stalled, st.arbitrated);
    end
    tests++;
    if (yumi !== 5'b01000) begin
      fails++;
      $display("FAIL clear_util_event: got y=%b want 01000", yumi);
    end
    tests++;
    tick();
    clear = 1'b0; req = 5'b0;
    #4;
    if (stat !== 128'b0) begin
      fails++;
      $display("FAIL clear_post: got %h want 0", stat);
    end
    tests++;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 5'b11111; ready = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    if (v !== 1'b0 || yumi !== 5'b0 || grant !== 5'b0) begin
      fails++;
      $display("FAIL async_reset_out: got v=%b g=%b y=%b want 0", v, grant, yumi);
    end
    tests++;
    if (stat !== 128'b0) begin
      fails++;
      $display("FAIL async_reset_stats: got %h want 0", stat);
    end
    tests++;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #2;
    if (grant !== 5'b00001 || yumi !== 5'b00001 || v !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_first: got g=%b y=%b want 00001", grant, yumi);
    end
    tests++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] eg, ey;
      eg = model_pick(req);
      ey = ready ? eg : 5'b0;
      #4;
      if (v !== (req != 0) || grant !== eg || yumi !== ey) begin
        fails++;
        $display("FAIL rand_out[%0d]: req=%b rdy=%b got v=%b g=%b y=%b want g=%b y=%b",
                 c, req, ready, v, grant, yumi, eg, ey);
      end
      tests++;
      if ({st.idle, st.utilized, st.stalled, st.arbitrated} !== {m_idle, m_util, m_stall, m_arb}) begin
        fails++;
        $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", c,
                 st.idle, st.utilized, st.stalled, st.arbitrated, m_idle, m_util, m_stall, m_arb);
      end
      tests++;
      tick();
      for (int i = 0; i < N; i++) begin
        if (ey[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 31) == 0);
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_starve();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mesh_router_output_scheduler.md
Name: mesh_router_output_scheduler

Overview:
- Per-output-port scheduler for the mesh router. Shares one output link among up to dirs_p input ports.
- Arbitration is round-robin, with an optional starvation guard.
- Drives the yumi handshake back to the input FIFOs.
- Keeps per-output idle/utilized/stalled/arbitrated counters in the same categories the router profiler reports, so profiling can read counters instead of re-deriving them.

Parameters:
- dirs_p, 5, number of requesting input ports (1+2*dims).
- starve_limit_p, 16, wait cycles after which a requester is treated as starving (>=1).
- stat_width_p, 32, width of each statistics counter.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset; asynchronous, active-high.
- req_i  input  dirs_p  per-input valid, already routed to this output.
- ready_i  input  1  downstream link ready.
- v_o  output  1  output valid (some request granted).
- grant_o  output  dirs_p  one-hot select for the output crossbar mux.
- yumi_o  output  dirs_p  dequeue to the granted input FIFO.
- clear_stat_i  input  1  synchronous clear of all statistics counters.
- stat_o  output  4*stat_width_p  packed router_sched_stat_s {idle, utilized, stalled, arbitrated}.

Behaviour:
- Input contract: req_i[i] may fall only in a cycle where yumi_o[i]=1. Any violation is flagged by an assertion.
- Grant is combinational, zero latency:
  - v_o = |req_i.
  - grant_o is one-hot when v_o=1, else 0.
  - yumi_o = grant_o & {dirs_p{ready_i}}.
  - While reset_i=1, v_o, grant_o and yumi_o are forced to 0.
- Round-robin state: last_r, $clog2(dirs_p) bits, resets to dirs_p-1 so input 0 has first priority.
  - Search order is last_r+1, last_r+2, ... modulo dirs_p.
  - last_r updates to the granted index only when v_o & ready_i.
  - grant_o may change while ready_i=0, but the pointer does not move.
- Wrap-around: when last_r = dirs_p-1, the search starts at 0.
- Statistics, all wrapping modulo 2^stat_width_p and reset to 0:
  - idle += (req_i==0).
  - utilized += (v_o & ready_i).
  - stalled += (v_o & ~ready_i).
  - arbitrated += ($countones(req_i)>1 & ready_i).
  - clear_stat_i=1 zeroes all four on the next edge. Clear takes priority over a same-cycle increment.
- Reset mid-operation clears last_r, the wait counters and the stats immediately. Outputs drop in the same cycle.

Optional Feature:
- Macro ROUTER_SCHED_STARVE_GUARD_EN.
- Defined:
  - Each input i has a wait counter wait_r[i] of $clog2(starve_limit_p+1) bits, reset 0.
  - wait_r[i] increments when req_i[i] & ~yumi_o[i], saturating at starve_limit_p.
  - wait_r[i] clears to 0 when yumi_o[i]=1 or req_i[i]=0.
  - If any wait_r[i]==starve_limit_p, the lowest-index such input overrides round-robin. last_r then updates to it on handshake.
- Undefined: no wait counters; pure round-robin. Port list is unchanged.

Decomposition:
- Package router_sched_pkg holds:
  - router_sched_stat_s (four stat_width_p fields, packed, idle in the MSBs).
  - Function for the pointer width.
- Sub-module router_sched_rr_pick: combinational one-hot picker over dirs_p requests with a start index. The top level also uses it with start 0 for the starvation override.

Test Plan:
- Reset then req_i=5'b00110, ready_i=1 for 4 cycles -> grants 1,2,1,2 in order; yumi_o each cycle; utilized=4, arbitrated=4, idle=0.
- req_i=5'b11111, ready_i=0 for 3 cycles, then 1 for 5 cycles -> no pointer motion while stalled (grant_o=00001); then grants 0,1,2,3,4; stalled=3, utilized=5.
- last_r=4 with req_i=5'b10001 -> grant input 0 (wrap); the next cycle with only req_i[4] -> grant 4.
- Macro defined, starve_limit_p=2, req_i[3] held while ready_i=0 for 2 cycles and others also requesting -> on the first ready_i=1 cycle input 3 is granted regardless of the pointer, and wait_r[3] returns to 0.
- Counters at 7 / 3 / 2 / 1 with clear_stat_i=1 and a simultaneous utilized event -> all read 0 next cycle. Assert reset_i asynchronously mid-burst -> v_o=0 and yumi_o=0 within the same cycle; after release input 0 is granted first.
